// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_ctrl                                                           |
// | Sequences one data-memory access per load/store with fault checks. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wrbits,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [6:0]    c_op_load  = 7'b0000011;
  localparam logic [6:0]    c_op_store = 7'b0100011;
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;

  logic [2:0]    w_f3;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_misal;
  logic [1:0]    w_dec_code;
  logic          w_accept;
  logic          w_ack;
  logic [1:0]    w_fault_code;
  logic [31:0]   w_st_data;
  logic [3:0]    w_st_bits;
  logic [31:0]   w_ld_shift;
  logic [31:0]   w_ld_data;
  logic          w_unused;

  assign w_f3     = ir[14:12];
  assign w_unused = ^{ir[31:15], ir[11:7]};

  always_comb begin
    w_is_load  = (ir[6:0] == c_op_load) &&
                 (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_is_store = (ir[6:0] == c_op_store) &&
                 (w_f3 inside {3'b000, 3'b001, 3'b010});
    w_misal    = ((w_f3[1:0] == 2'b01) && addr[0]) ||
                 ((w_f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    if (!(w_is_load || w_is_store)) begin
      w_dec_code = 2'b11;
    end else if (w_misal) begin
      w_dec_code = 2'b01;
    end else begin
      w_dec_code = 2'b00;
    end
  end

  // Byte lanes are replicated so memory picks the lane using the enables alone.
  always_comb begin
    w_st_data = wdata;
    w_st_bits = 4'b1111;
    case (w_f3[1:0])
      2'b00: begin
        w_st_data = {4{wdata[7:0]}};
        w_st_bits = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_st_data = {2{wdata[15:0]}};
        w_st_bits = 4'b0011 << addr[1:0];
      end
      default: begin
        w_st_data = wdata;
        w_st_bits = 4'b1111;
      end
    endcase
    if (!w_is_store) begin
      w_st_bits = 4'b0000;
    end
  end

  always_comb begin
    w_ld_shift = mem_rdata >> {r_off, 3'b000};
    case (r_f3)
      3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'b100:  w_ld_data = {24'h0, w_ld_shift[7:0]};
      3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b101:  w_ld_data = {16'h0, w_ld_shift[15:0]};
      default: w_ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ack        = 1'b0;
    w_fault_code = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_fault_code = w_dec_code;
          w_state_next = (w_dec_code == 2'b00) ? S_ACCESS : S_FAULT;
        end
      end
      S_ACCESS: begin
        // An ack in the final wait cycle still beats the timeout.
        if (mem_ack) begin
          w_ack        = 1'b1;
          w_state_next = S_RESP;
        end else if (r_cnt == c_cnt_last) begin
          w_fault_code = 2'b10;
          w_state_next = S_FAULT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_f3       <= 3'b000;
      r_off      <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wrbits <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'h0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      mem_req <= (w_state_next == S_ACCESS);
      busy    <= (w_state_next != S_IDLE);
      done    <= (w_state_next == S_RESP) || (w_state_next == S_FAULT);
      err     <= (w_state_next == S_FAULT);
      if (w_state_next == S_RESP) begin
        err_code <= 2'b00;
      end else if (w_state_next == S_FAULT) begin
        err_code <= w_fault_code;
      end
      if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_f3  <= w_f3;
        r_off <= addr[1:0];
        r_cnt <= '0;
      end
      if (w_accept && (w_dec_code == 2'b00)) begin
        mem_we     <= w_is_store;
        mem_addr   <= {addr[31:2], 2'b00};
        mem_wdata  <= w_st_data;
        mem_wrbits <= w_st_bits;
      end
      if (w_ack && !mem_we) begin
        rdata <= w_ld_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lsu_ctrl                                                        |
// | Randomized scoreboard bench for lsu_ctrl with a transaction model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = 32'h0, addr = 32'h0, wdata = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wrbits;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [1:0]  err_code;

  lsu_ctrl #(.TIMEOUT(TO), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wrbits(mem_wrbits), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected condition want none (t=%0t)", name, $time);
  endtask

  typedef struct {
    int          sc;
    int          lat;
    int          reqs;
    bit          err;
    logic [1:0]  code;
    logic [31:0] rd;
    bit          we;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [3:0]  wb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_rdata = 32'h0;

  // Transaction-level reference: outcome of one command from its fields.
  task automatic build(input logic [31:0] i, input logic [31:0] a, input logic [31:0] wd,
                       input int k, input logic [31:0] rd, output exp_t e);
    int op, f3, nb, off;
    bit ld, st;
    longint fld, m;
    op  = int'(i[6:0]);
    f3  = int'(i[14:12]);
    nb  = 1 << (f3 % 4);
    off = int'(a % 32'd4);
    ld  = (op == 3) && (f3 != 3) && (f3 < 6);
    st  = (op == 35) && (f3 < 3);
    e   = '{default: 0};
    e.sc = cyc;
    if (!ld && !st) begin
      e.lat = 1; e.err = 1; e.code = 2'd3;
    end else if ((a % 32'(nb)) != 0) begin
      e.lat = 1; e.err = 1; e.code = 2'd1;
    end else begin
      e.we = st;
      e.ma = a - 32'(off);
      if (st) begin
        e.wb  = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << off);
        e.mwd = (nb == 1) ? 32'(wd[7:0]) * 32'h01010101 :
                (nb == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
      end
      if (k <= TO) begin
        e.lat = k + 1; e.reqs = k;
        if (ld) begin
          fld = longint'(rd) >> (8 * off);
          if (nb < 4) begin
            m   = longint'(1) << (8 * nb);
            fld = fld % m;
            if (f3 < 4 && fld >= m / 2) fld = fld - m;
          end
          m_rdata = 32'(fld);
        end
      end else begin
        e.lat = TO + 1; e.reqs = TO; e.err = 1; e.code = 2'd2;
      end
    end
    e.rd = m_rdata;
  endtask

  // Memory responder: acks on the k-th request cycle, random ack noise when idle.
  int          ack_k = 1;
  logic [31:0] ack_data = 32'h0;
  int          rq = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      rq++;
      mem_ack   = (rq == ack_k);
      mem_rdata = (rq == ack_k) ? ack_data : $urandom;
    end else begin
      rq = 0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // Monitor / scoreboard.
  bit   mon_en = 1'b1;
  int   nreq = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      nreq = 0;
    end else begin
      if (mem_req) begin
        nreq++;
        if (q.size() == 0) fail("req_without_cmd");
        else begin
          chk("mem_we", 32'(mem_we), 32'(q[0].we));
          chk("mem_addr", mem_addr, q[0].ma);
          chk("mem_wrbits", 32'(mem_wrbits), 32'(q[0].wb));
          if (q[0].we) chk("mem_wdata", mem_wdata, q[0].mwd);
        end
      end
      if (done) begin
        if (q.size() == 0) fail("done_without_cmd");
        else begin
          me = q.pop_front();
          chk("latency", 32'(cyc - me.sc), 32'(me.lat));
          chk("req_cycles", 32'(nreq), 32'(me.reqs));
          chk("err", 32'(err), 32'(me.err));
          chk("err_code", 32'(err_code), 32'(me.code));
          chk("rdata", rdata, me.rd);
        end
        nreq = 0;
      end else if (err) begin
        fail("err_without_done");
      end
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    r[6:0] = op;
    return r;
  endfunction

  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] wd,
                       input int k, input logic [31:0] rd, input bit poke);
    exp_t e;
    int n;
    build(i, a, wd, k, rd, e);
    q.push_back(e);
    ack_k = k; ack_data = rd;
    start = 1'b1; ir = i; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0; ir = $urandom; addr = $urandom; wdata = $urandom;
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail("busy_stuck");
  endtask

  task automatic rand_one();
    int sel;
    logic [6:0] op;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    op  = (sel < 5) ? 7'h03 : (sel < 9) ? 7'h23 : 7'($urandom);
    a   = $urandom;
    if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
    issue(mk(op, 3'($urandom_range(0, 7))), a, $urandom, $urandom_range(1, TO + 2),
          $urandom, $urandom_range(0, 3) == 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wrbits", 32'(mem_wrbits), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(mk(7'h23, 3'd0), 32'h1003, 32'h000000A5, 1, $urandom, 1'b0);    // SB
    issue(mk(7'h03, 3'd0), 32'h2002, $urandom, 4, 32'h12F03456, 1'b0);    // LB
    chk("lb_value", rdata, 32'hFFFFFFF0);
    issue(mk(7'h03, 3'd4), 32'h2002, $urandom, 4, 32'h12F03456, 1'b0);    // LBU
    chk("lbu_value", rdata, 32'h000000F0);
    issue(mk(7'h03, 3'd2), 32'h0006, $urandom, 1, $urandom, 1'b0);        // LW misaligned
    issue(mk(7'h03, 3'd3), 32'h0000, $urandom, 1, $urandom, 1'b0);        // illegal funct3
    issue(mk(7'h23, 3'd1), 32'h0002, 32'h1234BEEF, 2, $urandom, 1'b0);    // SH
    issue(mk(7'h03, 3'd2), 32'h0100, $urandom, TO + 3, $urandom, 1'b0);   // timeout
    issue(mk(7'h03, 3'd2), 32'h0104, $urandom, TO, 32'hCAFEF00D, 1'b0);   // ack in last cycle
    issue(mk(7'h23, 3'd2), 32'h0208, $urandom, 3, $urandom, 1'b1);        // start while busy
    issue(mk(7'h03, 3'd1), 32'h0302, $urandom, 2, 32'h8001_7F00, 1'b1);   // LH

    // Reset in the middle of an access.
    mon_en = 1'b0;
    ack_k = 99;
    start = 1'b1; ir = mk(7'h03, 3'd2); addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rdata = 32'h0;
    chk("midrst_rdata", rdata, 0);
    @(negedge clk);
    mon_en = 1'b1;
    issue(mk(7'h03, 3'd5), 32'h0502, $urandom, 1, 32'hA5C3_1111, 1'b0);  // LHU after reset

    for (int t = 0; t < 300; t++) rand_one();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
